alu_chain_seq: RTL

//  Multi-precision sequencer for the NBITS-wide combinational ALU slice.

---
 rtl/alu_chain_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_chain_seq.sv
// alu_chain_seq: multi-precision sequencer for an NBITS-wide combinational ALU.
// Runs one (WORDS*NBITS)-bit operation by driving the shared ALU once per slice.
// It starts with the least-significant slice and handles one slice per clock.
// Carry and borrow pass between slices through the choice of the ALU opcode.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            request, accepted only while idle
//   cmd, opa, opb    operation and operands, latched on accept
//   busy             high while running and during the done cycle
//   done             one-cycle pulse when result/carry_out are valid
//   result           registered W-bit result, held until the next accept
//   carry_out        final carry (add) or borrow (sub); 0 for logic commands
//   alu_a/alu_b/op   slice operands and opcode driven to the ALU
//   alu_q, alu_c     combinational ALU result and carry/borrow
module alu_chain_seq #(
  parameter int NBITS = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             cmd,
  input  logic [NBITS*WORDS-1:0] opa,
  input  logic [NBITS*WORDS-1:0] opb,
  output logic                   busy,
  output logic                   done,
  output logic [NBITS*WORDS-1:0] result,
  output logic                   carry_out,
  output logic [NBITS-1:0]       alu_a,
  output logic [NBITS-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [NBITS:0]         alu_q,
  input  logic                   alu_c
);

  localparam int W  = NBITS * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_reg, b_reg;
  logic [2:0]      cmd_reg;
  logic            cy;

  // The ALU carry arrives separately on alu_c, so the MSB of alu_q is not needed.
  logic unused_msb;
  assign unused_msb = alu_q[NBITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cmd_reg   <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg   <= opa;
            b_reg   <= opb;
            cmd_reg <= cmd;
            idx     <= '0;
            cy      <= 1'b0;
          end
        end
        S_RUN: begin
          result[idx*NBITS +: NBITS] <= alu_q[NBITS-1:0];
          cy  <= alu_c;
          idx <= idx + 1'b1;
          if (idx == LAST)
            carry_out <= cmd_reg[2] ? 1'b0 : alu_c;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 3'b000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_a = a_reg[idx*NBITS +: NBITS];
        alu_b = b_reg[idx*NBITS +: NBITS];
        // Upper slices keep the add/sub family of cmd (bit 0).
        // The carry/borrow from the previous slice selects the +1 / -1 variant (bit 1).
        if (idx == '0 || cmd_reg[2])
          alu_op = cmd_reg;
        else
          alu_op = {1'b0, cy, cmd_reg[0]};
        if (idx == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
